jtag_tap_driver: RTL and testbench

- Host-side JTAG initiator that drives TCK/TMS/TDI into a target TAP and samples TDO.
- Converts command-level requests into legal TAP walks: TAP reset, IR scan, DR scan and idle clocks.
- Keeps an internal mirror of the target TAP state, using the same 4-bit encoding as the TAP controller FSM, so the debug transport can sequence scans without tracking TMS itself.

---
 rtl/jtag_tap_driver.sv | 265 ++++++++++++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver.sv
// jtag_tap_driver: host-side JTAG initiator. Turns TAP reset / IR scan /
// DR scan / idle-clock commands into TCK/TMS/TDI walks, captures TDO during
// shift cycles and keeps a mirror of the target TAP state.
//
// Handshakes: a command transfers on any clock edge where req_valid and
// req_ready are both high; a response transfers on any edge where rsp_valid
// and rsp_ready are both high. rsp_valid, rsp_data and rsp_err hold steady
// until that edge, and req_ready is never high while rsp_valid is high.
module jtag_tap_driver #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [6:0]         req_len,
    input  logic [MAX_LEN-1:0] req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo,
    output logic               busy,
    output logic [3:0]         tap_state,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    localparam logic [3:0] ST_TLR   = 4'hF;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_PAUDR = 4'h3;
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_UPDDR = 4'h5;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_PAUIR = 4'hB;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_UPDIR = 4'hD;

    localparam int              DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_RESP = 2'd2
    } ctrl_t;

    ctrl_t              ctrl_q, ctrl_d;
    logic [1:0]         op_q;
    logic [6:0]         len_q;
    logic [MAX_LEN-1:0] data_q;   // remaining TDI bits, current bit at [0]
    logic [MAX_LEN-1:0] cap_q;    // captured TDO bits, cleared at accept
    logic [6:0]         bit_cnt;  // shift bits done / idle TCKs in RTI / reset TCKs
    logic [DW-1:0]      div_cnt;

    // Standard IEEE 1149.1 TAP transition table on the 4-bit state encoding.
    function automatic logic [3:0] tap_step(input logic [3:0] s, input logic t);
        case (s)
            ST_TLR:   tap_step = t ? ST_TLR   : ST_RTI;
            ST_RTI:   tap_step = t ? ST_SELDR : ST_RTI;
            ST_SELDR: tap_step = t ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: tap_step = t ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  tap_step = t ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: tap_step = t ? ST_UPDDR : ST_PAUDR;
            ST_PAUDR: tap_step = t ? ST_EX2DR : ST_PAUDR;
            ST_EX2DR: tap_step = t ? ST_UPDDR : ST_SHDR;
            ST_UPDDR: tap_step = t ? ST_SELDR : ST_RTI;
            ST_SELIR: tap_step = t ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: tap_step = t ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  tap_step = t ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: tap_step = t ? ST_UPDIR : ST_PAUIR;
            ST_PAUIR: tap_step = t ? ST_EX2IR : ST_PAUIR;
            ST_EX2IR: tap_step = t ? ST_UPDIR : ST_SHIR;
            default:  tap_step = t ? ST_SELDR : ST_RTI;  // ST_UPDIR
        endcase
    endfunction

    logic               is_scan_q, in_shift, end_high, walk_last, bit_inc;
    logic               req_scan, req_bad, req_nop;
    logic [3:0]         tap_nxt;
    logic [MAX_LEN-1:0] data_nxt;

    logic [1:0]         p_op;
    logic [6:0]         p_len, p_cnt;
    logic [3:0]         p_state;
    logic [MAX_LEN-1:0] p_data;
    logic               plan_tms, plan_tdi;

    // Walk bookkeeping: phase end, counter step and end-of-walk detection.
    always_comb begin
        is_scan_q = (op_q == OP_IR) || (op_q == OP_DR);
        in_shift  = (tap_state == ST_SHDR) || (tap_state == ST_SHIR);
        end_high  = jtag_tck && (div_cnt == DIV_MAX);
        tap_nxt   = tap_step(tap_state, jtag_tms);
        req_scan  = (req_op == OP_IR) || (req_op == OP_DR);
        req_bad   = req_scan && ((req_len == 7'd0) || (int'(req_len) > MAX_LEN));
        req_nop   = (req_op == OP_IDLE) && (req_len == 7'd0);
        bit_inc   = 1'b0;
        walk_last = 1'b0;
        case (op_q)
            OP_RESET: begin
                bit_inc   = 1'b1;
                walk_last = (bit_cnt == 7'd5);
            end
            OP_IDLE: begin
                bit_inc   = (tap_state == ST_RTI);
                walk_last = (tap_state == ST_RTI) && (bit_cnt == len_q - 7'd1);
            end
            default: begin
                bit_inc   = in_shift;
                walk_last = (tap_state == ST_UPDDR) || (tap_state == ST_UPDIR);
            end
        endcase
        data_nxt = (is_scan_q && in_shift) ? (data_q >> 1) : data_q;
    end

    // TMS/TDI for the next TCK cycle: from the incoming request at accept,
    // otherwise from the state the mirror is about to enter.
    always_comb begin
        if (ctrl_q == S_IDLE) begin
            p_op    = req_op;
            p_len   = req_len;
            p_state = tap_state;
            p_cnt   = 7'd0;
            p_data  = req_data;
        end else begin
            p_op    = op_q;
            p_len   = len_q;
            p_state = tap_nxt;
            p_cnt   = bit_cnt + {6'd0, bit_inc};
            p_data  = data_nxt;
        end
        plan_tms = 1'b0;
        plan_tdi = 1'b0;
        case (p_op)
            OP_RESET: plan_tms = (p_cnt != 7'd5);
            OP_IDLE:  plan_tms = 1'b0;
            default: begin
                case (p_state)
                    ST_TLR:                plan_tms = 1'b0;
                    ST_RTI:                plan_tms = 1'b1;
                    ST_SELDR:              plan_tms = (p_op == OP_IR);
                    ST_SELIR:              plan_tms = 1'b0;
                    ST_CAPDR, ST_CAPIR:    plan_tms = 1'b0;
                    ST_SHDR, ST_SHIR: begin
                        plan_tms = (p_cnt == p_len - 7'd1);
                        plan_tdi = p_data[0];
                    end
                    ST_EX1DR, ST_EX1IR:    plan_tms = 1'b1;
                    ST_UPDDR, ST_UPDIR:    plan_tms = 1'b0;
                    default:               plan_tms = 1'b1;
                endcase
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ctrl_q <= S_IDLE;
        else       ctrl_q <= ctrl_d;
    end

    // Controller next state: illegal scans and zero-length idles skip the walk.
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            S_IDLE: if (req_valid) ctrl_d = (req_bad || req_nop) ? S_RESP : S_WALK;
            S_WALK: if (end_high && walk_last) ctrl_d = S_RESP;
            S_RESP: if (rsp_ready) ctrl_d = S_IDLE;
            default: ctrl_d = S_IDLE;
        endcase
    end

    // Controller outputs decoded from state.
    always_comb begin
        req_ready = (ctrl_q == S_IDLE);
        busy      = (ctrl_q == S_WALK);
        rsp_valid = (ctrl_q == S_RESP);
        dbg_state = ctrl_q;
    end

    // TCK generation, TMS/TDI launch, TDO capture and TAP mirror update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            tap_state <= ST_TLR;
            op_q      <= OP_RESET;
            len_q     <= 7'd0;
            data_q    <= '0;
            cap_q     <= '0;
            bit_cnt   <= 7'd0;
            div_cnt   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (ctrl_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        len_q   <= req_len;
                        data_q  <= req_data;
                        cap_q   <= '0;
                        bit_cnt <= 7'd0;
                        div_cnt <= '0;
                        if (req_bad || req_nop) begin
                            rsp_data <= '0;
                            rsp_err  <= req_bad;
                        end else begin
                            jtag_tck <= 1'b0;
                            jtag_tms <= plan_tms;
                            jtag_tdi <= plan_tdi;
                        end
                    end
                end
                S_WALK: begin
                    // TDO is taken on the first clock of the high phase.
                    if (jtag_tck && (div_cnt == '0) && is_scan_q && in_shift) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (bit_cnt == 7'(i)) cap_q[i] <= jtag_tdo;
                        end
                    end
                    if (div_cnt == DIV_MAX) begin
                        div_cnt  <= '0;
                        jtag_tck <= ~jtag_tck;
                        if (jtag_tck) begin
                            tap_state <= tap_nxt;
                            bit_cnt   <= bit_cnt + {6'd0, bit_inc};
                            data_q    <= data_nxt;
                            if (walk_last) begin
                                jtag_tdi <= 1'b0;
                                rsp_data <= is_scan_q ? cap_q : '0;
                                rsp_err  <= 1'b0;
                            end else begin
                                jtag_tms <= plan_tms;
                                jtag_tdi <= plan_tdi;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver (CLK_DIV=2, MAX_LEN=64). Responses are
// scored from an expected queue by a monitor; TCK-level behaviour is logged
// at each TCK rise and compared with hand-computed patterns.
module tb_jtag_tap_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [6:0]  req_len = 7'd0;
    logic [63:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
    logic        busy;
    logic [3:0]  tap_state;
    logic [1:0]  dbg_state;

    jtag_tap_driver #(.CLK_DIV(2), .MAX_LEN(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_len(req_len), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .busy(busy), .tap_state(tap_state),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // target model: 0 = TDI looped back one TCK later, 1 = tied high, 2 = tied low
    int   tdo_mode = 0;
    logic last_tdi = 1'b0;
    logic loop_q = 1'b0;
    always @(posedge jtag_tck) last_tdi <= jtag_tdi;
    always @(negedge jtag_tck) loop_q <= last_tdi;
    assign jtag_tdo = (tdo_mode == 1) ? 1'b1 : (tdo_mode == 2) ? 1'b0 : loop_q;

    // TCK-level log, newest entry in the low bits
    int           tck_cnt = 0;
    int           shift_rises = 0;
    logic [127:0] tms_log = '0;
    logic [127:0] tdi_log = '0;
    logic [255:0] st_log = '0;

    always @(posedge jtag_tck) begin
        tck_cnt = tck_cnt + 1;
        tms_log = {tms_log[126:0], jtag_tms};
        tdi_log = {tdi_log[126:0], jtag_tdi};
        st_log  = {st_log[251:0], tap_state};
        if (tap_state == 4'h2) shift_rises = shift_rises + 1;
    end

    task automatic clear_log();
        tck_cnt = 0;
        shift_rises = 0;
        tms_log = '0;
        tdi_log = '0;
        st_log = '0;
    endtask

    // scoreboard: {rsp_err, rsp_data}
    logic [64:0] exp_q[$];

    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {255'd0, rsp_valid}, 256'd0);
            end else begin
                check("rsp_err_data", {191'd0, rsp_err, rsp_data}, {191'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
        int n;
        @(negedge clock);
        req_op = op;
        req_len = len;
        req_data = data;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("req_accept", {255'd0, req_ready}, 256'd1);
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit consume, output int lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        lat = cyc - acc_cyc;
        check("rsp_arrive", {255'd0, rsp_valid}, 256'd1);
        if (consume) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int held_valid, held_data, held_noready, held_tck, seen;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_tck", {255'd0, jtag_tck}, 256'd0);
        check("rst_tms", {255'd0, jtag_tms}, 256'd1);
        check("rst_tdi", {255'd0, jtag_tdi}, 256'd0);
        check("rst_req_ready", {255'd0, req_ready}, 256'd1);
        check("rst_rsp_valid", {255'd0, rsp_valid}, 256'd0);
        check("rst_rsp_err", {255'd0, rsp_err}, 256'd0);
        check("rst_rsp_data", {192'd0, rsp_data}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_tap_state", {252'd0, tap_state}, 256'hF);

        // DR scan len 8 of 0xA5 from TLR with loopback: captured = 0xA5 << 1 (8 bits)
        tdo_mode = 0;
        clear_log();
        exp_q.push_back({1'b0, 64'h4A});
        send(2'd2, 7'd8, 64'hA5);
        wait_rsp(1'b1, lat);
        check("dr8_latency", lat, 56);
        check("dr8_tck_count", tck_cnt, 14);
        check("dr8_tms", {242'd0, tms_log[13:0]}, {242'd0, 14'b01000000000110});
        check("dr8_tdi", {242'd0, tdi_log[13:0]}, {242'd0, 14'b00001010010100});
        check("dr8_path", {200'd0, st_log[55:0]}, {200'd0, 56'hFC762222222215});
        check("dr8_end_state", {252'd0, tap_state}, 256'hC);

        // IR scan len 5 of 0x11 with TDO tied high
        tdo_mode = 1;
        clear_log();
        exp_q.push_back({1'b0, 64'h1F});
        send(2'd1, 7'd5, 64'h11);
        wait_rsp(1'b1, lat);
        check("ir5_tck_count", tck_cnt, 11);
        check("ir5_tms", {245'd0, tms_log[10:0]}, {245'd0, 11'b11000000110});
        check("ir5_tdi", {245'd0, tdi_log[10:0]}, {245'd0, 11'b00001000100});
        check("ir5_path", {212'd0, st_log[43:0]}, {212'd0, 44'hC74EAAAAA9D});
        check("ir5_end_state", {252'd0, tap_state}, 256'hC);

        // TAP reset from RTI
        clear_log();
        exp_q.push_back({1'b0, 64'h0});
        send(2'd0, 7'd9, 64'hFFFF);
        wait_rsp(1'b1, lat);
        check("rst_op_tck_count", tck_cnt, 6);
        check("rst_op_tms", {250'd0, tms_log[5:0]}, {250'd0, 6'b111110});
        check("rst_op_path", {232'd0, st_log[23:0]}, {232'd0, 24'hC74FFF});
        check("rst_op_end_state", {252'd0, tap_state}, 256'hC);

        // illegal scan lengths: 0 and 65
        clear_log();
        exp_q.push_back({1'b1, 64'h0});
        send(2'd2, 7'd0, 64'h1234);
        wait_rsp(1'b1, lat);
        exp_q.push_back({1'b1, 64'h0});
        send(2'd2, 7'd65, 64'h5678);
        wait_rsp(1'b1, lat);
        check("bad_len_tck_count", tck_cnt, 0);
        check("bad_len_state", {252'd0, tap_state}, 256'hC);

        // response held with rsp_ready low; competing request must wait
        tdo_mode = 1;
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 64'hF});
        send(2'd2, 7'd4, 64'h3);
        wait_rsp(1'b0, lat);
        clear_log();
        exp_q.push_back({1'b0, 64'h0});
        req_op = 2'd3;
        req_len = 7'd2;
        req_data = '0;
        req_valid = 1'b1;
        held_valid = 0; held_data = 0; held_noready = 0; held_tck = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_valid) held_valid++;
            if (rsp_data == 64'hF && !rsp_err) held_data++;
            if (!req_ready && !busy) held_noready++;
        end
        held_tck = tck_cnt;
        check("hold_valid", held_valid, 10);
        check("hold_data", held_data, 10);
        check("hold_no_accept", held_noready, 10);
        check("hold_no_tck", held_tck, 0);
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("after_rsp_req_ready", {255'd0, req_ready}, 256'd1);
        @(negedge clock);
        check("second_cmd_busy", {255'd0, busy}, 256'd1);
        req_valid = 1'b0;
        wait_rsp(1'b1, lat);
        check("idle2_tck_count", tck_cnt, 2);
        check("idle2_tms", {254'd0, tms_log[1:0]}, 256'd0);

        // reset during the 3rd shift cycle of a 32-bit DR scan
        tdo_mode = 2;
        clear_log();
        send(2'd2, 7'd32, 64'hDEADBEEF);
        n = 0;
        while (shift_rises < 3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("reach_shift3", shift_rises, 3);
        reset = 1'b1;
        #1;
        check("abort_tck", {255'd0, jtag_tck}, 256'd0);
        check("abort_tms", {255'd0, jtag_tms}, 256'd1);
        check("abort_state", {252'd0, tap_state}, 256'hF);
        check("abort_busy", {255'd0, busy}, 256'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", seen, 0);

        // idle 1 from TLR inserts the TLR->RTI cycle first
        clear_log();
        exp_q.push_back({1'b0, 64'h0});
        send(2'd3, 7'd1, 64'hFF);
        wait_rsp(1'b1, lat);
        check("idle1_tck_count", tck_cnt, 2);
        check("idle1_path", {248'd0, st_log[7:0]}, {248'd0, 8'hFC});
        check("idle1_end_state", {252'd0, tap_state}, 256'hC);

        repeat (4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
